// File: rtl/desc_replay_pkg.sv
// desc_replay_pkg: shared defaults, state encoding and pass-tag values for the
// descriptor replay buffer.
package desc_replay_pkg;

    localparam int unsigned DESC_DATA_W = 64;  // 4 x 16-bit elements per beat
    localparam int unsigned DESC_DEPTH  = 64;  // 256 elements / 4 per beat

    typedef enum logic {
        CAPTURE,
        REPLAY
    } state_t;

    // Value carried on m_axis_tuser for each pass (DESC_PASS_TAG_EN builds)
    localparam logic PASS_TAG_P1 = 1'b0;
    localparam logic PASS_TAG_P2 = 1'b1;

endpackage

// File: rtl/desc_replay_buffer_if.sv
// desc_replay_buffer_if: AXI-Stream beat bundle (data/valid/last/ready) used for
// both the input and output side of the replay buffer.
interface desc_replay_buffer_if #(
    parameter int unsigned DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/desc_replay_ram.sv
// desc_replay_ram: simple dual-port RAM, one write port and one registered read
// port. No reset on the array or read register so it maps onto BRAM/LUTRAM.
module desc_replay_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; rdata holds its value while re is low
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/desc_replay_buffer.sv
// desc_replay_buffer: forwards each descriptor vector live as pass 1 while
// capturing it into RAM, then replays it as pass 2. Optional build macro
// DESC_PASS_TAG_EN adds m_axis_tuser (pass tag) and vec_done_cnt.
module desc_replay_buffer
    import desc_replay_pkg::*;
#(
    parameter int unsigned DATA_W = DESC_DATA_W,
    parameter int unsigned DEPTH  = DESC_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    desc_replay_buffer_if.slave  s_axis,
    desc_replay_buffer_if.master m_axis,
`ifdef DESC_PASS_TAG_EN
    output logic                 m_axis_tuser,
    output logic [15:0]          vec_done_cnt,
`endif
    output logic                 busy,
    output logic                 overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  rd_addr_q, rd_addr_d;   // next RAM address to issue
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;   // index of beat at the output
    logic              rd_vld_q, rd_vld_d;     // RAM read register holds a beat
    logic              hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] s_tdata, m_tdata, ram_rdata;
    logic              s_tvalid, s_tlast, s_tready;
    logic              m_tvalid, m_tlast, m_tready;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic              force_last, pop, hold_keep, rd_keep, issue, done_hs;

    assign s_tdata  = s_axis.tdata;
    assign s_tvalid = s_axis.tvalid;
    assign s_tlast  = s_axis.tlast;
    assign m_tready = m_axis.tready;

    assign s_axis.tready = s_tready;
    assign m_axis.tdata  = m_tdata;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tlast  = m_tlast;

    assign busy     = (state_q == REPLAY);
    assign overflow = overflow_q;

    desc_replay_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_cnt_q),
        .wdata (s_tdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Next-state, output mux and two-entry replay skid control
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        len_d       = len_q;
        rd_addr_d   = rd_addr_q;
        out_idx_d   = out_idx_q;
        rd_vld_d    = rd_vld_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        overflow_d  = overflow_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_raddr   = rd_addr_q[ADDR_W-1:0];
        m_tdata     = s_tdata;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        s_tready    = 1'b0;
        force_last  = 1'b0;
        pop         = 1'b0;
        hold_keep   = 1'b0;
        rd_keep     = 1'b0;
        issue       = 1'b0;
        done_hs     = 1'b0;

        unique case (state_q)
            CAPTURE: begin
                // Live pass-through; gated by rstn so nothing leaks out in reset
                force_last = (wr_cnt_q == ADDR_W'(DEPTH - 1));
                m_tdata    = s_tdata;
                m_tvalid   = s_tvalid & rstn;
                m_tlast    = (s_tlast | force_last) & rstn;
                s_tready   = m_tready & rstn;
                if (s_tvalid && m_tready) begin
                    ram_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (s_tlast || force_last) begin
                        len_d     = {1'b0, wr_cnt_q} + CNT_W'(1);
                        wr_cnt_d  = '0;
                        state_d   = REPLAY;
                        out_idx_d = '0;
                        rd_addr_d = CNT_W'(1);
                        ram_raddr = '0;
                        if (!s_tlast) overflow_d = 1'b1;
                        if (wr_cnt_q == '0) begin
                            // Address 0 is being written right now, so the RAM
                            // would return stale data: seed the holding register.
                            hold_vld_d  = 1'b1;
                            hold_data_d = s_tdata;
                            rd_vld_d    = 1'b0;
                        end else begin
                            ram_re     = 1'b1;
                            rd_vld_d   = 1'b1;
                            hold_vld_d = 1'b0;
                        end
                    end
                end
            end
            REPLAY: begin
                // Holding register is always the older beat when both are valid
                m_tvalid  = hold_vld_q | rd_vld_q;
                m_tdata   = hold_vld_q ? hold_data_q : ram_rdata;
                m_tlast   = m_tvalid & (out_idx_q == len_q - CNT_W'(1));
                pop       = m_tvalid & m_tready;
                hold_keep = hold_vld_q & ~pop;
                rd_keep   = rd_vld_q & ~(pop & ~hold_vld_q);
                // Issue only if the beat landing next cycle has a free slot
                issue     = (rd_addr_q < len_q) & ~(hold_keep & rd_keep);
                ram_re    = issue;
                if (issue) rd_addr_d = rd_addr_q + CNT_W'(1);
                hold_vld_d  = hold_keep | (rd_keep & issue);
                hold_data_d = hold_keep ? hold_data_q : ram_rdata;
                rd_vld_d    = issue | rd_keep;
                if (pop) begin
                    out_idx_d = out_idx_q + CNT_W'(1);
                    if (m_tlast) begin
                        done_hs    = 1'b1;
                        state_d    = CAPTURE;
                        out_idx_d  = '0;
                        rd_addr_d  = '0;
                        rd_vld_d   = 1'b0;
                        hold_vld_d = 1'b0;
                    end
                end
            end
            default: state_d = CAPTURE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= CAPTURE;
            wr_cnt_q    <= '0;
            len_q       <= '0;
            rd_addr_q   <= '0;
            out_idx_q   <= '0;
            rd_vld_q    <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            len_q       <= len_d;
            rd_addr_q   <= rd_addr_d;
            out_idx_q   <= out_idx_d;
            rd_vld_q    <= rd_vld_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef DESC_PASS_TAG_EN
    logic [15:0] vec_done_q;

    assign m_axis_tuser = (state_q == REPLAY) ? PASS_TAG_P2 : PASS_TAG_P1;
    assign vec_done_cnt = vec_done_q;

    // Saturating count of completed pass-2 vectors
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vec_done_q <= '0;
        end else if (done_hs && (vec_done_q != 16'hFFFF)) begin
            vec_done_q <= vec_done_q + 16'd1;
        end
    end
`else
    logic unused_done_hs;
    assign unused_done_hs = done_hs;
`endif

endmodule
